scp_mc_controller: RTL

- Multi-cycle, parametrised successor to the single-cycle SCP controller for the 32-bit accumulator processor.
- Accepts one instruction at a time over a valid/ready handshake and decodes a wider opcode.
- Sequences memory/IO accesses with a ready handshake, performs multi-cycle shifts by a programmable amount, and reports completion and illegal opcodes.
- Sits between the instruction fetch unit and the datapath (accumulator, ALU, shifter, memory/IO mux).

---
 rtl/scp_ctrl_pkg.sv | 51 +++++
 rtl/scp_down_counter.sv | 35 +++
 rtl/scp_mc_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/scp_ctrl_pkg.sv
// rtl/scp_ctrl_pkg.sv - shared encodings for the multi-cycle SCP controller
// Contents:
//   op_e      decoded opcode (OP_ILL stands for any undefined opcode)
//   state_e   controller state encoding
//   control-output encodings for AcSel, ShiftDir, IOMemSel, AddSub
//   helpers   classify an opcode as read / write / IO access
package scp_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_STORE = 4'd2,
    OP_IN    = 4'd3,
    OP_OUT   = 4'd4,
    OP_ADD   = 4'd5,
    OP_SUB   = 4'd6,
    OP_SHL   = 4'd7,
    OP_SHR   = 4'd8,
    OP_ILL   = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MEM   = 3'd1,
    ST_WB    = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic ACSEL_ALU   = 1'b0;
  localparam logic ACSEL_MEM   = 1'b1;
  localparam logic SHDIR_LEFT  = 1'b0;
  localparam logic SHDIR_RIGHT = 1'b1;
  localparam logic IOSEL_MEM   = 1'b0;
  localparam logic IOSEL_IO    = 1'b1;
  localparam logic ALU_ADD     = 1'b0;
  localparam logic ALU_SUB     = 1'b1;

  function automatic logic op_is_read(input op_e op);
    return (op == OP_LOAD) || (op == OP_IN) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_is_write(input op_e op);
    return (op == OP_STORE) || (op == OP_OUT);
  endfunction

  function automatic logic op_is_io(input op_e op);
    return (op == OP_IN) || (op == OP_OUT);
  endfunction

endpackage

// File: rtl/scp_down_counter.sv
// rtl/scp_down_counter.sv - loadable down counter with zero/one flags
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         load load_val (has priority over dec)
//   load_val     value to load
//   dec          decrement by one; saturates at zero
//   zero, one    count == 0, count == 1
module scp_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule

// File: rtl/scp_mc_controller.sv
// rtl/scp_mc_controller.sv - multi-cycle controller for the 32-bit accumulator processor
// Optional feature macro: SCP_MEM_TIMEOUT_EN (memory-wait timeout with busErr)
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   instrValid/instrReady         instruction handshake; ready only in IDLE
//   opCode [OPW], shAmt [SHW]     instruction opcode and shift count
//   memReady                      memory/IO completes current Rd/Wr
//   start                         instruction in flight
//   AddSub, LoadAcc, AcSel        ALU op, accumulator load strobe and source
//   Rd, Wr, IOMemSel              memory/IO request and target
//   Shift, ShiftDir               one-bit shift strobe and direction
//   done, illegal, busErr         completion pulse and its qualifiers
module scp_mc_controller
  import scp_ctrl_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int SHW    = 5,
  parameter int TO_CYC = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instrValid,
  output logic           instrReady,
  input  logic [OPW-1:0] opCode,
  input  logic [SHW-1:0] shAmt,
  input  logic           memReady,
  output logic           start,
  output logic           AddSub,
  output logic           LoadAcc,
  output logic           AcSel,
  output logic           Rd,
  output logic           Wr,
  output logic           IOMemSel,
  output logic           Shift,
  output logic           ShiftDir,
  output logic           done,
  output logic           illegal,
  output logic           busErr
);

  // One counter serves both shift counting and the memory timeout, so it
  // must hold the larger of the two ranges.
  localparam int TOW = $clog2(TO_CYC + 1);
  localparam int CW  = (SHW > TOW) ? SHW : TOW;

  state_e        state_q, state_d;
  op_e           op_q, op_in;
  logic [31:0]   op_ext;
  logic          accept;
  logic          cnt_load, cnt_dec, cnt_zero, cnt_one;
  logic [CW-1:0] cnt_val;
`ifdef SCP_MEM_TIMEOUT_EN
  logic          to_err, bus_err_q;
`endif

  // Any opcode above SHR, including non-zero upper bits, is illegal.
  always_comb begin
    op_ext = 32'(opCode);
    if (op_ext > 32'd8) op_in = OP_ILL;
    else                op_in = op_e'(op_ext[3:0]);
  end

  scp_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
`ifdef SCP_MEM_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      if (accept) op_q <= op_in;
`ifdef SCP_MEM_TIMEOUT_EN
      // to_err only fires on the MEM->DONE edge, so this is high in DONE only.
      bus_err_q <= to_err;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
`ifdef SCP_MEM_TIMEOUT_EN
    to_err   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (instrValid) begin
          accept = 1'b1;
          case (op_in)
            OP_LOAD, OP_STORE, OP_IN, OP_OUT, OP_ADD, OP_SUB: begin
              state_d  = ST_MEM;
`ifdef SCP_MEM_TIMEOUT_EN
              cnt_load = 1'b1;
              cnt_val  = CW'(TO_CYC);
`endif
            end
            OP_SHL, OP_SHR: begin
              if (shAmt != '0) begin
                state_d  = ST_SHIFT;
                cnt_load = 1'b1;
                cnt_val  = CW'(shAmt);
              end else begin
                state_d  = ST_DONE;
              end
            end
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_MEM: begin
        // memReady has priority over the timeout expiring in the same cycle.
        if (memReady) begin
          state_d = op_is_write(op_q) ? ST_DONE : ST_WB;
        end
`ifdef SCP_MEM_TIMEOUT_EN
        else if (cnt_one || cnt_zero) begin
          state_d = ST_DONE;
          to_err  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
`endif
      end
      ST_WB:    state_d = ST_DONE;
      ST_SHIFT: begin
        // Leaving at count 1 yields exactly shAmt strobes.
        cnt_dec = 1'b1;
        if (cnt_one || cnt_zero) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instrReady = (state_q == ST_IDLE);
    start      = (state_q != ST_IDLE);
    Rd         = 1'b0;
    Wr         = 1'b0;
    IOMemSel   = IOSEL_MEM;
    LoadAcc    = 1'b0;
    AcSel      = ACSEL_ALU;
    AddSub     = ALU_ADD;
    Shift      = 1'b0;
    ShiftDir   = SHDIR_LEFT;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_MEM: begin
        Rd       = op_is_read(op_q);
        Wr       = op_is_write(op_q);
        IOMemSel = op_is_io(op_q) ? IOSEL_IO : IOSEL_MEM;
      end
      ST_WB: begin
        LoadAcc = 1'b1;
        AcSel   = ((op_q == OP_LOAD) || (op_q == OP_IN)) ? ACSEL_MEM : ACSEL_ALU;
        AddSub  = (op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
      end
      ST_SHIFT: begin
        Shift    = 1'b1;
        ShiftDir = (op_q == OP_SHR) ? SHDIR_RIGHT : SHDIR_LEFT;
      end
      ST_DONE: begin
        done    = 1'b1;
        illegal = (op_q == OP_ILL);
      end
      default: ;
    endcase
  end

`ifdef SCP_MEM_TIMEOUT_EN
  assign busErr = bus_err_q;
`else
  assign busErr = 1'b0;
`endif

endmodule
